// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Drives the per-stage write/bubble and hold enables, PC write and PC source.
// Resolves memory wait states, taken-branch flushes and load-use hazards.
// Also runs a fixed-length pipeline clear after reset.
//
// Handshake: the data memory is modelled as a level handshake.
// While exmem_mem_access=1 and mem_ready=0, the access is outstanding and the
// pipeline is frozen.
// The access completes on the rising edge where mem_ready=1 is sampled.
// Outside an access, mem_ready has no effect.
module pipe_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        exmem_branch,
  input  logic        exmem_zero,
  input  logic        exmem_mem_access,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_src,
  output logic        pwrite1,
  output logic        pwrite2,
  output logic        pwrite3,
  output logic        pwrite4,
  output logic        hold1,
  output logic        hold2,
  output logic        hold3,
  output logic        hold4,
  output logic        mem_timeout,
  output logic [15:0] stall_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  localparam int unsigned IW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_LAST  = IW'((INIT_CYCLES == 0) ? 0 : INIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_V  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_M1 = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [IW-1:0] init_cnt;
  logic [TW-1:0] wait_cnt;
  logic [4:1]    pw, hd;
  logic          mem_stall, taken_branch, load_use;
  logic          eval_run, eval_mem_stall, wait_tick, stall_inc;

  assign mem_stall    = exmem_mem_access & ~mem_ready;
  assign taken_branch = exmem_branch & exmem_zero;
  assign load_use     = idex_mem_read && (idex_rt != 5'd0) &&
                        ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  assign {pwrite4, pwrite3, pwrite2, pwrite1} = pw;
  assign {hold4, hold3, hold2, hold1}         = hd;
  assign dbg_state = state;

  // Next-state selection and stage-enable decode with fixed hazard priority.
  always_comb begin
    state_nxt      = state;
    eval_run       = 1'b0;
    eval_mem_stall = 1'b0;
    wait_tick      = 1'b0;
    stall_inc      = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 1'b0;
    pw             = 4'b0000;
    hd             = 4'b0000;

    case (state)
      S_INIT: begin
        if ((INIT_CYCLES == 0) || (init_cnt == INIT_LAST)) state_nxt = S_RUN;
      end
      S_RUN: begin
        eval_run = 1'b1;
        if (mem_stall) begin
          eval_mem_stall = 1'b1;
          state_nxt      = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_ready) begin
          eval_mem_stall = 1'b1;
          wait_tick      = 1'b1;
        end else begin
          // The access completes here, so the memory term is dropped.
          eval_run  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_INIT;
    endcase

    if (eval_mem_stall) begin
      // Freeze the front of the pipe and bubble MEM/WB.
      pc_write  = 1'b0;
      pw        = 4'b0111;
      hd        = 4'b0111;
      stall_inc = 1'b1;
    end else if (eval_run) begin
      pc_write = 1'b1;
      pw       = 4'b1111;
      if (taken_branch) begin
        // Redirect the PC and squash the three younger instructions.
        pc_src = 1'b1;
        pw     = 4'b1000;
      end else if (load_use) begin
        // Hold IF/ID and PC and insert a single bubble into ID/EX.
        pc_write  = 1'b0;
        hd        = 4'b0001;
        pw        = 4'b1101;
        stall_inc = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Post-reset clear counter, counting cycles spent in INIT.
  always_ff @(posedge clk) begin
    if (!rst_n)                                         init_cnt <= '0;
    else if ((state == S_INIT) && (state_nxt == S_INIT)) init_cnt <= init_cnt + 1'b1;
    else                                                init_cnt <= '0;
  end

  // Wait-state counter: counts outstanding MEM_WAIT cycles and saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst_n)                                  wait_cnt <= '0;
    else if (!wait_tick)                         wait_cnt <= '0;
    else if (wait_cnt != TIMEOUT_V)              wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky timeout flag, raised on the wait cycle that brings the counter to TIMEOUT.
  always_ff @(posedge clk) begin
    if (!rst_n)                                  mem_timeout <= 1'b0;
    else if (wait_tick && (wait_cnt >= TIMEOUT_M1)) mem_timeout <= 1'b1;
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (!rst_n)                                     stall_count <= 16'd0;
    else if (stall_inc && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl: a vector table for single-cycle
// RUN behaviour, plus hand-written sequences for reset, memory wait,
// timeout and counter saturation.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idex_mem_read;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        exmem_branch, exmem_zero, exmem_mem_access, mem_ready;
  logic        pc_write, pc_src;
  logic        pwrite1, pwrite2, pwrite3, pwrite4;
  logic        hold1, hold2, hold3, hold4;
  logic        mem_timeout;
  logic [15:0] stall_count;
  logic [1:0]  dbg_state;
  logic [9:0]  out_vec;

  // {pc_write, pc_src, pwrite1..4, hold1..4}
  localparam logic [9:0] O_ZERO = 10'b0_0_0000_0000;
  localparam logic [9:0] O_DEF  = 10'b1_0_1111_0000;
  localparam logic [9:0] O_BR   = 10'b1_1_0001_0000;
  localparam logic [9:0] O_LU   = 10'b0_0_1011_1000;
  localparam logic [9:0] O_MW   = 10'b0_0_1110_1110;
  localparam logic [1:0] ST_INIT = 2'd0, ST_RUN = 2'd1, ST_WAIT = 2'd2;

  typedef struct {
    logic       mr;
    logic [4:0] irt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       z;
    logic       acc;
    logic       rdy;
    logic [9:0] exp_out;
    int         inc;
  } vec_t;

  vec_t       vecs[15];
  logic [9:0] exp_q[$];
  int         n_total = 0;
  int         n_pass  = 0;
  int         exp_stall = 0;

  pipe_hazard_ctrl #(.INIT_CYCLES(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_mem_access(exmem_mem_access), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src),
    .pwrite1(pwrite1), .pwrite2(pwrite2), .pwrite3(pwrite3), .pwrite4(pwrite4),
    .hold1(hold1), .hold2(hold2), .hold3(hold3), .hold4(hold4),
    .mem_timeout(mem_timeout), .stall_count(stall_count), .dbg_state(dbg_state)
  );

  assign out_vec = {pc_write, pc_src, pwrite1, pwrite2, pwrite3, pwrite4,
                    hold1, hold2, hold3, hold4};

  // Clock.
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic z,
                       input logic acc, input logic rdy);
    idex_mem_read    = mr;
    idex_rt          = irt;
    ifid_rs          = rs;
    ifid_rt          = rt;
    exmem_branch     = br;
    exmem_zero       = z;
    exmem_mem_access = acc;
    mem_ready        = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int sat_inc(input int v, input int n);
    return ((v + n) > 65535) ? 65535 : (v + n);
  endfunction

  // Stimulus and checking.
  initial begin
    vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 0};
    vecs[1]  = '{1'b1, 5'd8,  5'd8,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, O_LU,  1};
    vecs[2]  = '{1'b0, 5'd0,  5'd8,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 0};
    vecs[3]  = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 0};
    vecs[4]  = '{1'b1, 5'd17, 5'd2,  5'd17, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,  1};
    vecs[5]  = '{1'b0, 5'd9,  5'd9,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 0};
    vecs[6]  = '{1'b1, 5'd8,  5'd9,  5'd10, 1'b0, 1'b0, 1'b0, 1'b0, O_DEF, 0};
    vecs[7]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, O_BR,  0};
    vecs[8]  = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_DEF, 0};
    vecs[9]  = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, O_BR,  0};
    vecs[10] = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_LU,  1};
    vecs[11] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, O_DEF, 0};
    vecs[12] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, O_DEF, 0};
    vecs[13] = '{1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, O_BR,  0};
    vecs[14] = '{1'b1, 5'd31, 5'd31, 5'd4,  1'b0, 1'b0, 1'b0, 1'b0, O_LU,  1};

    // Reset and post-reset clear.
    rst_n = 1'b0;
    idle();
    repeat (2) cycle();
    check("rst_state", dbg_state, ST_INIT);
    check("rst_out", out_vec, O_ZERO);
    check("rst_stall", stall_count, 0);
    check("rst_timeout", mem_timeout, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("init_out%0d", i), out_vec, O_ZERO);
      cycle();
    end
    #1 check("run_state", dbg_state, ST_RUN);
    check("run_out", out_vec, O_DEF);
    check("run_stall", stall_count, 0);

    // Single-cycle vectors in RUN.
    foreach (vecs[k]) begin
      drive(vecs[k].mr, vecs[k].irt, vecs[k].rs, vecs[k].rt,
            vecs[k].br, vecs[k].z, vecs[k].acc, vecs[k].rdy);
      exp_q.push_back(vecs[k].exp_out);
      #1 check($sformatf("vec%0d_out", k), out_vec, exp_q.pop_front());
      cycle();
      exp_stall = sat_inc(exp_stall, vecs[k].inc);
      check($sformatf("vec%0d_stall", k), stall_count, exp_stall);
      check($sformatf("vec%0d_state", k), dbg_state, ST_RUN);
    end

    // Three-cycle memory wait, plain.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("mw%0d_out", i), out_vec, O_MW);
      cycle();
      exp_stall = sat_inc(exp_stall, 1);
      check($sformatf("mw%0d_state", i), dbg_state, ST_WAIT);
    end
    mem_ready = 1'b1;
    #1 check("mw_ready_out", out_vec, O_DEF);
    cycle();
    check("mw_done_state", dbg_state, ST_RUN);
    check("mw_done_stall", stall_count, exp_stall);

    // Memory wait with branch and load-use pending: flush only on the ready cycle.
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("mwb%0d_out", i), out_vec, O_MW);
      cycle();
      exp_stall = sat_inc(exp_stall, 1);
    end
    check("mwb_stall", stall_count, exp_stall);
    mem_ready = 1'b1;
    #1 check("mwb_ready_out", out_vec, O_BR);
    cycle();
    check("mwb_done_state", dbg_state, ST_RUN);
    check("mwb_done_stall", stall_count, exp_stall);

    // One wait cycle, then ready together with a load-use.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("mwl_wait_out", out_vec, O_MW);
    cycle();
    exp_stall = sat_inc(exp_stall, 1);
    drive(1'b1, 5'd12, 5'd1, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 check("mwl_ready_out", out_vec, O_LU);
    cycle();
    exp_stall = sat_inc(exp_stall, 1);
    check("mwl_stall", stall_count, exp_stall);
    check("mwl_state", dbg_state, ST_RUN);
    idle();
    #1 check("idle_out", out_vec, O_DEF);
    cycle();

    // Timeout: 300 cycles of outstanding access (1 RUN cycle + 299 wait cycles).
    check("to_pre", mem_timeout, 0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      cycle();
      exp_stall = sat_inc(exp_stall, 1);
      if (i == 254) check("to_before", mem_timeout, 0);
      if (i == 255) check("to_rise", mem_timeout, 1);
    end
    check("to_sticky", mem_timeout, 1);
    check("to_state", dbg_state, ST_WAIT);
    check("to_stall", stall_count, exp_stall);

    // Reset in the middle of the wait.
    rst_n = 1'b0;
    cycle();
    check("midrst_state", dbg_state, ST_INIT);
    check("midrst_timeout", mem_timeout, 0);
    check("midrst_stall", stall_count, 0);
    #1 check("midrst_out", out_vec, O_ZERO);
    rst_n = 1'b1;
    exp_stall = 0;

    // Long wait for saturation; INIT cycles are not counted.
    repeat (4) cycle();
    check("sat_init_stall", stall_count, 0);
    check("sat_run_state", dbg_state, ST_RUN);
    for (int i = 0; i < 70000; i++) begin
      cycle();
      if (i == 65533) check("sat_fffe", stall_count, 16'hFFFE);
      if (i == 65534) check("sat_ffff", stall_count, 16'hFFFF);
    end
    check("sat_hold", stall_count, 16'hFFFF);
    check("sat_timeout", mem_timeout, 1);
    mem_ready = 1'b1;
    cycle();
    check("sat_exit_state", dbg_state, ST_RUN);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("sat_lu_out", out_vec, O_LU);
    cycle();
    check("sat_lu_stall", stall_count, 16'hFFFF);
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
